compressed_bit_packer: RTL
==========================

# compressed_bit_packer

Downstream neighbour of the length-generation stage in the compression pipeline. Each cycle it takes up to two variable-length compressed word fields (code plus payload, length already computed upstream) and appends them MSB-first into a bit buffer. It emits fixed `CACHE_LINE`-bit chunks over a valid/ready stream. On the last beat of a line it flushes the partial chunk with zero padding and reports the line's total compressed size.

## Interface
- `CACHE_LINE`, 128: output chunk width; buffer is `2*CACHE_LINE` bits.
- `MAX_FIELD`, 34: max bits per word field (2-bit code + 32-bit payload).
- `LEN_W`, 6: width of per-field length inputs.
- `LINE_BITS_W`, 16: width of line size counter.
- `i_clk`  in  1  clock; all state on rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  upstream beat valid.
- `o_ready`  out  1  beat accepted when `i_valid && o_ready`.
- `i_field1`, `i_field2`  in  `MAX_FIELD`  right-aligned field bits; bits at/above length are ignored.
- `i_length1`, `i_length2`  in  `LEN_W`  field lengths, 0..`MAX_FIELD`; word1 is packed before word2.
- `i_last`  in  1  beat is the last of the current cache line.
- `o_out_valid`  out  1  chunk valid.
- `i_out_ready`  in  1  consumer ready.
- `o_out_data`  out  `CACHE_LINE`  chunk; bit `CACHE_LINE-1` is the oldest bit.
- `o_out_last`  out  1  chunk closes the line.
- `o_line_done`  out  1  one-cycle pulse after the last chunk handshakes.
- `o_line_bits`  out  `LINE_BITS_W`  total field bits of the completed line; held until the next `o_line_done`.

## Operation
- State: `buf` (`2*CACHE_LINE`, MSB-first), `count` (valid bits, 0..256), `acc` (line bit accumulator), FSM {`ACCUM`, `FLUSH`}.
- `o_ready = (state==ACCUM) && (count <= 2*CACHE_LINE - 2*MAX_FIELD)`, i.e. `count ≤ 188`. The buffer can never overflow.
- Emit condition:
  - In `ACCUM`: `count > CACHE_LINE`.
  - In `FLUSH`: always.
- `o_out_data = buf[2*CACHE_LINE-1 -: CACHE_LINE]`. Bits below `count` are zero, so a partial chunk is zero-padded.
- Handshake (`o_out_valid && i_out_ready`):
  - `buf <<= CACHE_LINE`.
  - `count = max(count - CACHE_LINE, 0)`.
- Append on accepted beat:
  - Field1 goes at `buf[2*CACHE_LINE-1-c' -: L1]`; field2 follows immediately after.
  - `c'` is `count` after any same-cycle emission.
  - New `count = c' + L1 + L2`.
  - `acc += L1 + L2`.
- Accepted beat with `i_last`: state → `FLUSH`.
- `o_out_last = (state==FLUSH) && (count <= CACHE_LINE)`.
- If `count==0` on entry to `FLUSH`, one all-zero chunk is emitted with `o_out_last=1`.
- Last handshake in `FLUSH`:
  - State → `ACCUM`, `count=0`, `buf=0`.
  - `o_line_bits <= acc + 0`; `acc <= 0`.
  - `o_line_done` pulses the following cycle.
- Length > `MAX_FIELD` is illegal. A bench assertion flags it; RTL behaviour is unspecified.
- Simultaneous emit and append: permitted in `ACCUM`. Appended bits always land below bit `CACHE_LINE`, so `o_out_data` is unaffected.

## Timing
- Reset values:
  - `o_out_valid=0`, `o_out_data=0`, `o_out_last=0`.
  - `o_line_done=0`, `o_line_bits=0`.
  - `count=0`, `acc=0`, state `ACCUM`.
  - `o_ready=1` in the first cycle after reset deasserts.
- `o_ready`, `o_out_valid`, `o_out_data` and `o_out_last` are combinational from registers only. There is no input-to-output combinational path.
- Latency: a beat accepted in cycle N is reflected in `count` and `buf` in cycle N+1. The earliest chunk containing it is valid in N+1.
- Stability: while `o_out_valid && !i_out_ready`, `o_out_data` and `o_out_last` are held stable.
- Back-pressure: an upstream stall only lowers `o_ready`. `o_ready` is 0 throughout `FLUSH`.
- Reset mid-operation: buffered bits are discarded, no line report is made, and the block returns to reset values.

## Structure
- Package `compress_pkg`:
  - `CACHE_LINE`, `MAX_FIELD`, `LEN_W` defaults.
  - `packer_state_t` enum {`ACCUM`, `FLUSH`}.
  - Per-code length constants, shared with the length-generation stage.
- Sub-module `field_concat` (combinational): masks both fields to their lengths and produces a left-aligned `2*MAX_FIELD` vector plus a 7-bit total length. The top level does the shift/OR into `buf`.

## Test plan
- Single line, 4 beats of L1=L2=34, `i_last` on beat 4 (272 bits):
  - Chunks 1 and 2 are full; chunk 3 holds 16 bits plus 112 zeros with `o_out_last=1`.
  - `o_line_bits=272`.
- Line of 2 beats, lengths (2,2), (6,12), `i_last` on beat 2:
  - One chunk whose top 22 bits equal the concatenation and the rest are zero, `o_out_last=1`.
  - `o_line_bits=22`, `o_line_done` one cycle after handshake.
- Exactly 128 bits (L1=L2=32, 2 beats, `i_last`):
  - No emission in `ACCUM`; one full chunk with `o_out_last=1`; `o_line_bits=128`.
- `i_out_ready=0` for 20 cycles with continuous 68-bit beats:
  - `o_ready` drops at `count>188`, and `o_out_data` stays stable.
  - After release, all bits arrive in order with no loss or duplication.
- Lengths 0/0 with `i_last` on the first beat:
  - One all-zero chunk with `o_out_last=1`; `o_line_bits=0`.
- Reset asserted with `count=100` in `ACCUM`:
  - Next cycle `count=0`, `o_out_valid=0`, no `o_line_done`.
  - A following line packs from bit 127.

Source files
------------

// File: rtl/compress_pkg.sv
// Shared definitions for the compression pipeline.
//   - default chunk / field / length widths
//   - packer FSM state type
//   - per-code field lengths (2-bit code + payload), also used by the
//     length-generation stage so both sides agree on field sizes
package compress_pkg;

    localparam int CACHE_LINE  = 128;
    localparam int MAX_FIELD   = 34;
    localparam int LEN_W       = 6;
    localparam int LINE_BITS_W = 16;

    localparam int CODE_W   = 2;
    localparam int LEN_ZERO = CODE_W;        // code 00: all-zero word, code only
    localparam int LEN_BYTE = CODE_W + 8;    // code 01: 8-bit payload
    localparam int LEN_HALF = CODE_W + 16;   // code 10: 16-bit payload
    localparam int LEN_FULL = CODE_W + 32;   // code 11: uncompressed word

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        FLUSH = 1'b1
    } packer_state_t;

    function automatic logic [LEN_W-1:0] code_length(input logic [CODE_W-1:0] code);
        logic [LEN_W-1:0] len;
        len = LEN_W'(LEN_ZERO);
        case (code)
            2'b00:   len = LEN_W'(LEN_ZERO);
            2'b01:   len = LEN_W'(LEN_BYTE);
            2'b10:   len = LEN_W'(LEN_HALF);
            default: len = LEN_W'(LEN_FULL);
        endcase
        return len;
    endfunction

endpackage

// File: rtl/field_concat.sv
// Combinational merge of the two per-beat fields.
// Masks each right-aligned field to its length and stacks them MSB-first
// into a left-aligned vector (field1 on top, field2 directly below it).
// Ports:
//   field1, field2   right-aligned field bits (bits at/above length ignored)
//   length1, length2 field lengths, 0..MAX_FIELD
//   packed_bits      left-aligned concatenation, 2*MAX_FIELD bits
//   total_len        length1 + length2
module field_concat
    import compress_pkg::*;
#(
    parameter int MAX_FIELD = compress_pkg::MAX_FIELD,
    parameter int LEN_W     = compress_pkg::LEN_W,
    localparam int FW       = 2 * MAX_FIELD,
    localparam int TOT_W    = $clog2(FW + 1)
) (
    input  logic [MAX_FIELD-1:0] field1,
    input  logic [MAX_FIELD-1:0] field2,
    input  logic [LEN_W-1:0]     length1,
    input  logic [LEN_W-1:0]     length2,
    output logic [FW-1:0]        packed_bits,
    output logic [TOT_W-1:0]     total_len
);

    logic [LEN_W-1:0]     len1_c;
    logic [LEN_W-1:0]     len2_c;
    logic [MAX_FIELD-1:0] mask1;
    logic [MAX_FIELD-1:0] mask2;
    logic [FW-1:0]        f1_ext;
    logic [FW-1:0]        f2_ext;
    logic [TOT_W-1:0]     sh1;
    logic [TOT_W-1:0]     sh2;

    always_comb begin
        // Illegal lengths are clamped so the shift amounts never wrap.
        len1_c = (length1 > LEN_W'(MAX_FIELD)) ? LEN_W'(MAX_FIELD) : length1;
        len2_c = (length2 > LEN_W'(MAX_FIELD)) ? LEN_W'(MAX_FIELD) : length2;

        // Shifting a full-width vector by MAX_FIELD yields zero -> all-ones mask.
        mask1 = ~({MAX_FIELD{1'b1}} << len1_c);
        mask2 = ~({MAX_FIELD{1'b1}} << len2_c);

        f1_ext = {{MAX_FIELD{1'b0}}, field1 & mask1};
        f2_ext = {{MAX_FIELD{1'b0}}, field2 & mask2};

        sh1 = TOT_W'(FW) - TOT_W'(len1_c);
        sh2 = sh1 - TOT_W'(len2_c);

        packed_bits = (f1_ext << sh1) | (f2_ext << sh2);
        total_len   = TOT_W'(len1_c) + TOT_W'(len2_c);
    end

endmodule

// File: rtl/compressed_bit_packer.sv
// Packs up to two variable-length fields per beat into an MSB-first bit
// buffer and streams fixed CACHE_LINE-bit chunks. The last beat of a line
// flushes the partial chunk zero-padded and reports the line's bit total.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   ACCUM | accepting beats; emit a chunk whenever more than a line is held
//   FLUSH | line closed; drain every chunk, last one zero-padded, no input
//
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_valid / o_ready      upstream beat handshake
//   i_field1/2, i_length1/2 fields and their lengths (field1 packed first)
//   i_last                 beat closes the current line
//   o_out_valid/i_out_ready chunk handshake
//   o_out_data, o_out_last chunk bits (MSB oldest), chunk closes the line
//   o_line_done            one-cycle pulse after the closing chunk
//   o_line_bits            bit total of the last completed line
module compressed_bit_packer
    import compress_pkg::*;
#(
    parameter int CACHE_LINE  = compress_pkg::CACHE_LINE,
    parameter int MAX_FIELD   = compress_pkg::MAX_FIELD,
    parameter int LEN_W       = compress_pkg::LEN_W,
    parameter int LINE_BITS_W = compress_pkg::LINE_BITS_W
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [MAX_FIELD-1:0]   i_field1,
    input  logic [MAX_FIELD-1:0]   i_field2,
    input  logic [LEN_W-1:0]       i_length1,
    input  logic [LEN_W-1:0]       i_length2,
    input  logic                   i_last,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [CACHE_LINE-1:0]  o_out_data,
    output logic                   o_out_last,
    output logic                   o_line_done,
    output logic [LINE_BITS_W-1:0] o_line_bits
);

    localparam int BUF_W = 2 * CACHE_LINE;
    localparam int FW    = 2 * MAX_FIELD;
    localparam int CNT_W = $clog2(BUF_W + 1);
    localparam int TOT_W = $clog2(FW + 1);

    localparam logic [CNT_W-1:0] CNT_LINE      = CNT_W'(CACHE_LINE);
    // Highest fill at which a worst-case beat still fits in the buffer.
    localparam logic [CNT_W-1:0] CNT_READY_MAX = CNT_W'(BUF_W - FW);

    packer_state_t          state_q;
    logic [BUF_W-1:0]       buf_q;
    logic [CNT_W-1:0]       count_q;
    logic [LINE_BITS_W-1:0] acc_q;
    logic [LINE_BITS_W-1:0] line_bits_q;
    logic                   line_done_q;

    logic [FW-1:0]    packed_bits;
    logic [TOT_W-1:0] total_len;

    logic             emit;
    logic             accept;
    logic [BUF_W-1:0] buf_shift;
    logic [CNT_W-1:0] count_shift;
    logic [BUF_W-1:0] append_vec;
    logic [BUF_W-1:0] buf_next;
    logic [CNT_W-1:0] count_next;

    field_concat #(
        .MAX_FIELD (MAX_FIELD),
        .LEN_W     (LEN_W)
    ) u_field_concat (
        .field1      (i_field1),
        .field2      (i_field2),
        .length1     (i_length1),
        .length2     (i_length2),
        .packed_bits (packed_bits),
        .total_len   (total_len)
    );

    always_comb begin
        o_out_valid = (state_q == FLUSH) || (count_q > CNT_LINE);
        o_out_last  = (state_q == FLUSH) && (count_q <= CNT_LINE);
        o_ready     = (state_q == ACCUM) && (count_q <= CNT_READY_MAX);
        o_out_data  = buf_q[BUF_W-1 -: CACHE_LINE];

        emit   = o_out_valid && i_out_ready;
        accept = i_valid && o_ready;

        buf_shift   = buf_q;
        count_shift = count_q;
        if (emit) begin
            buf_shift   = buf_q << CACHE_LINE;
            count_shift = (count_q > CNT_LINE) ? (count_q - CNT_LINE) : '0;
        end

        // New bits land right behind whatever survives this cycle's emission.
        append_vec = {packed_bits, {(BUF_W - FW){1'b0}}} >> count_shift;

        buf_next   = buf_shift;
        count_next = count_shift;
        if (accept) begin
            buf_next   = buf_shift | append_vec;
            count_next = count_shift + CNT_W'(total_len);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ACCUM;
            buf_q       <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            line_bits_q <= '0;
            line_done_q <= 1'b0;
        end else begin
            line_done_q <= 1'b0;
            if (emit && o_out_last) begin
                state_q     <= ACCUM;
                buf_q       <= '0;
                count_q     <= '0;
                line_bits_q <= acc_q;
                acc_q       <= '0;
                line_done_q <= 1'b1;
            end else begin
                buf_q   <= buf_next;
                count_q <= count_next;
                if (accept) begin
                    acc_q <= acc_q + LINE_BITS_W'(total_len);
                    if (i_last) begin
                        state_q <= FLUSH;
                    end
                end
            end
        end
    end

    assign o_line_done = line_done_q;
    assign o_line_bits = line_bits_q;

endmodule
